// File: rtl/max_pool_2x2.sv
// Stride-2 2x2 pooling stage: tracks the raster position of each accepted pixel
// and emits one pooled byte per (odd row, odd col) window. `define POOL_AVG_EN for average pooling.
module max_pool_2x2 #(
  parameter int DATA_W   = 8,
  parameter int MAP_SIZE = 14
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr,
  input  logic              en,
  input  logic [DATA_W-1:0] win_tl,
  input  logic [DATA_W-1:0] win_tr,
  input  logic [DATA_W-1:0] win_bl,
  input  logic [DATA_W-1:0] win_br,
  output logic [DATA_W-1:0] pool_data,
  output logic              pool_valid,
  output logic              map_done
);

  localparam int CNT_W  = (MAP_SIZE > 2) ? $clog2(MAP_SIZE) : 1;
  localparam int OUT_N  = (MAP_SIZE / 2) * (MAP_SIZE / 2);
  localparam int OCNT_W = (OUT_N > 1) ? $clog2(OUT_N) : 1;

  localparam logic [CNT_W-1:0]  POS_LAST = CNT_W'(MAP_SIZE - 1);
  localparam logic [OCNT_W-1:0] OUT_LAST = OCNT_W'(OUT_N - 1);

  logic [CNT_W-1:0]  col;
  logic [CNT_W-1:0]  row;
  logic [OCNT_W-1:0] ocnt;
  logic              samp;
  logic [DATA_W-1:0] pooled;

`ifdef POOL_AVG_EN
  logic [DATA_W+1:0] win_sum;

  always_comb begin
    win_sum = {2'b00, win_tl} + {2'b00, win_tr} + {2'b00, win_bl} + {2'b00, win_br};
    pooled  = win_sum[DATA_W+1:2];
  end
`else
  logic [DATA_W-1:0] max_top;
  logic [DATA_W-1:0] max_bot;

  // Two-level compare tree: row-wise maxima, then the larger of the two.
  always_comb begin
    max_top = (win_tl > win_tr) ? win_tl : win_tr;
    max_bot = (win_bl > win_br) ? win_bl : win_br;
    pooled  = (max_top > max_bot) ? max_top : max_bot;
  end
`endif

  // Raster position of the next pixel; the final pixel wraps back to (0,0).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col <= '0;
      row <= '0;
    end else if (clr) begin
      col <= '0;
      row <= '0;
    end else if (en) begin
      if (col == POS_LAST) begin
        col <= '0;
        row <= (row == POS_LAST) ? '0 : row + CNT_W'(1);
      end else begin
        col <= col + CNT_W'(1);
      end
    end
  end

  // samp marks the cycle in which the window inputs hold a full odd/odd window.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      samp <= 1'b0;
    end else if (clr) begin
      samp <= 1'b0;
    end else begin
      samp <= en & row[0] & col[0];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pool_data  <= '0;
      pool_valid <= 1'b0;
      map_done   <= 1'b0;
      ocnt       <= '0;
    end else if (clr) begin
      pool_valid <= 1'b0;
      map_done   <= 1'b0;
      ocnt       <= '0;
    end else begin
      pool_valid <= samp;
      map_done   <= samp && (ocnt == OUT_LAST);
      if (samp) begin
        pool_data <= pooled;
        ocnt      <= (ocnt == OUT_LAST) ? '0 : ocnt + OCNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_max_pool_2x2.sv
// Randomized scoreboard bench for max_pool_2x2: a raster/line-buffer model drives
// the window inputs and queues expected outputs; a negedge monitor compares them.
module tb_max_pool_2x2;

  localparam int DW = 8;
  localparam int MS = 14;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          clr = 1'b0;
  logic          en = 1'b0;
  logic [DW-1:0] win_tl = '0;
  logic [DW-1:0] win_tr = '0;
  logic [DW-1:0] win_bl = '0;
  logic [DW-1:0] win_br = '0;
  logic [DW-1:0] pool_data;
  logic          pool_valid;
  logic          map_done;

  max_pool_2x2 #(.DATA_W(DW), .MAP_SIZE(MS)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr       (clr),
    .en        (en),
    .win_tl    (win_tl),
    .win_tr    (win_tr),
    .win_bl    (win_bl),
    .win_br    (win_br),
    .pool_data (pool_data),
    .pool_valid(pool_valid),
    .map_done  (map_done)
  );

  always #5 clk = ~clk;

  typedef struct {
    int data;
    bit done;
    int cyc;
  } exp_t;

  exp_t sbq[$];
  exp_t mon_e;
  exp_t drop_e;
  int   errors = 0;
  int   checks = 0;
  int   cyc = 0;
  int   n_out = 0;
  int   n_done = 0;
  int   img[MS][MS];
  int   r_pos = 0;
  int   c_pos = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int got, input int want);
    checks++;
    if (got != want) begin
      errors++;
      $display("FAIL %s: got=%0d expected=%0d (cycle %0d)", name, got, want, cyc);
    end
  endtask

  // Reference pooling of one 2x2 window, straight from the definition.
  function automatic int ref_pool(input int tl, input int tr, input int bl, input int br);
`ifdef POOL_AVG_EN
    return (tl + tr + bl + br) / 4;
`else
    int m;
    m = tl;
    if (tr > m) m = tr;
    if (bl > m) m = bl;
    if (br > m) m = br;
    return m;
`endif
  endfunction

  // One clock of stimulus; on acceptance the line-buffer model is updated and the
  // window for the just-accepted pixel is presented for the following cycle.
  task automatic step(input bit e, input int val, input bit c);
    exp_t x;
    en  = e;
    clr = c;
    @(posedge clk);
    #1;
    en  = 1'b0;
    clr = 1'b0;
    if (c) begin
      r_pos = 0;
      c_pos = 0;
    end else if (e) begin
      img[r_pos][c_pos] = val;
      win_br = DW'(val);
      if (r_pos > 0 && c_pos > 0) begin
        win_tl = DW'(img[r_pos-1][c_pos-1]);
        win_tr = DW'(img[r_pos-1][c_pos]);
        win_bl = DW'(img[r_pos][c_pos-1]);
      end
      if ((r_pos % 2 == 1) && (c_pos % 2 == 1)) begin
        x.data = ref_pool(img[r_pos-1][c_pos-1], img[r_pos-1][c_pos],
                          img[r_pos][c_pos-1], val);
        x.done = (r_pos == MS - 1) && (c_pos == MS - 1);
        x.cyc  = cyc + 1;
        sbq.push_back(x);
      end
      c_pos++;
      if (c_pos == MS) begin
        c_pos = 0;
        r_pos = (r_pos + 1) % MS;
      end
    end
  endtask

  // mode 0: raster values r*MS+c; mode 1: random bytes. duty in percent.
  task automatic feed_n(input int n, input int mode, input int duty);
    int v;
    for (int i = 0; i < n; i++) begin
      while ($urandom_range(99) >= duty) step(1'b0, 0, 1'b0);
      v = (mode == 0) ? (r_pos * MS + c_pos) : int'($urandom_range(255));
      step(1'b1, v, 1'b0);
    end
  endtask

  task automatic drain;
    int k;
    k = 0;
    while (sbq.size() != 0 && k < 50) begin
      step(1'b0, 0, 1'b0);
      k++;
    end
    repeat (3) step(1'b0, 0, 1'b0);
    chk("queue_drained", sbq.size(), 0);
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      if (pool_valid) begin
        n_out++;
        if (map_done) n_done++;
        if (sbq.size() == 0) begin
          chk("unexpected_output", int'(pool_data), -1);
        end else begin
          mon_e = sbq.pop_front();
          chk("pool_data", int'(pool_data), mon_e.data);
          chk("map_done", int'(map_done), int'(mon_e.done));
          chk("latency_cycle", cyc, mon_e.cyc);
        end
      end else begin
        chk("done_without_valid", int'(map_done), 0);
      end
    end
  end

  initial begin
    int n0;
    int d0;
    int w0, w1, w2, w3;
    #200000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n0;
    int d0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_pool_data", int'(pool_data), 0);
    chk("reset_pool_valid", int'(pool_valid), 0);
    chk("reset_map_done", int'(map_done), 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Raster map, en every cycle.
    n0 = n_out; d0 = n_done;
    feed_n(MS * MS, 0, 100);
    drain();
    chk("raster_outputs", n_out - n0, 49);
    chk("raster_dones", n_done - d0, 1);

    // Same raster with 50% en duty.
    n0 = n_out;
    feed_n(MS * MS, 0, 50);
    drain();
    chk("gappy_outputs", n_out - n0, 49);

    // Fixed window at the first sample point, rest of the map random.
    step(1'b1, 200, 1'b0);
    step(1'b1, 7, 1'b0);
    feed_n(MS - 2, 1, 100);
    step(1'b1, 255, 1'b0);
    step(1'b1, 3, 1'b0);
    step(1'b0, 0, 1'b0);
    chk("fixed_window_valid", int'(pool_valid), 1);
`ifdef POOL_AVG_EN
    chk("fixed_window_data", int'(pool_data), 116);
`else
    chk("fixed_window_data", int'(pool_data), 255);
`endif
    feed_n(MS * MS - MS - 2, 1, 100);
    drain();

    // Two random maps back to back.
    n0 = n_out; d0 = n_done;
    feed_n(2 * MS * MS, 1, 100);
    drain();
    chk("two_map_outputs", n_out - n0, 98);
    chk("two_map_dones", n_done - d0, 2);

    // clr together with en at pixel (5,9), then a fresh map.
    n0 = n_out;
    feed_n(5 * MS + 9, 0, 100);
    step(1'b1, 5 * MS + 9, 1'b1);
    step(1'b0, 0, 1'b0);
    step(1'b0, 0, 1'b0);
    chk("clr_no_output", int'(pool_valid), 0);
    feed_n(MS * MS, 0, 100);
    drain();
    chk("clr_outputs", n_out - n0, 18 + 49);

    // Async reset while samp is high for pixel (1,1).
    feed_n(MS + 1, 0, 100);
    step(1'b1, MS + 1, 1'b0);
    rst_n = 1'b0;
    if (sbq.size() != 0) drop_e = sbq.pop_back();
    #1;
    chk("rst_pool_valid", int'(pool_valid), 0);
    chk("rst_pool_data", int'(pool_data), 0);
    @(posedge clk);
    #1;
    chk("rst_hold_valid", int'(pool_valid), 0);
    chk("rst_hold_data", int'(pool_data), 0);
    @(negedge clk);
    rst_n = 1'b1;
    r_pos = 0;
    c_pos = 0;
    n0 = n_out; d0 = n_done;
    feed_n(MS * MS, 0, 100);
    drain();
    chk("post_rst_outputs", n_out - n0, 49);
    chk("post_rst_dones", n_done - d0, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
